// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-ported synchronous memory between an instruction-fetch
//   port and a data (load/store) port. One transaction is in flight at a time.
//   A three-state FSM (IDLE -> ISSUE -> WAIT -> IDLE) latches the winning
//   request in IDLE, strobes the memory for exactly one cycle in ISSUE, then
//   waits LATENCY cycles and passes m_rdata straight through to the granted
//   port together with its one-cycle ack.
//
// Configuration:
//   MEM_ARBITER_RR_EN  undefined : fixed priority, data port wins a tie.
//                      defined   : round-robin on ties. The pointer flips to
//                                  the other port on every grant and resets
//                                  to "instruction preferred".
//
// Parameters:
//   LATENCY  cycles from the m_en cycle to valid m_rdata (1..4).
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_req/i_addr      fetch request and byte address (held until i_ack)
//   i_rdata/i_ack     fetch data (0 unless i_ack) and completion pulse
//   d_req/d_addr      data request and byte address (held until d_ack)
//   d_wdata/d_be      store data and byte enables (d_be == 0 means load)
//   d_rdata/d_ack     load data (0 unless d_ack) and completion pulse
//   m_en              one-cycle memory strobe per transaction
//   m_addr/m_wdata    memory address / write data (0 outside the strobe)
//   m_be              memory byte enables (0 outside the strobe)
//   m_rdata           memory read data, valid LATENCY cycles after m_en
//   gnt_d             1 while the data port owns the memory
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata,
    output logic        gnt_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Counter value in WAIT on which the memory data is valid.
    localparam logic [1:0] CNT_LAST = 2'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        grant_data_q, grant_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        pick_data;
    logic        ack_now;

`ifdef MEM_ARBITER_RR_EN
    logic        prefer_data_q, prefer_data_d;
`endif

    // Arbitration: which port wins if a grant is taken this cycle.
    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        if (i_req && d_req) begin
            pick_data = prefer_data_q;
        end else begin
            pick_data = d_req;
        end
`else
        pick_data = d_req;
`endif
    end

    // Next-state logic. Requests are only looked at in IDLE, so anything the
    // requesters do during ISSUE/WAIT cannot disturb the latched transaction.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_data_d = grant_data_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
`ifdef MEM_ARBITER_RR_EN
        prefer_data_d = prefer_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_data_d = pick_data;
                    addr_d       = pick_data ? d_addr  : i_addr;
                    wdata_d      = pick_data ? d_wdata : 32'd0;
                    be_d         = pick_data ? d_be    : 4'd0;
                    state_d      = ISSUE;
`ifdef MEM_ARBITER_RR_EN
                    prefer_data_d = ~pick_data;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = 2'd0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            grant_data_q <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
`ifdef MEM_ARBITER_RR_EN
            prefer_data_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_data_q <= grant_data_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
`ifdef MEM_ARBITER_RR_EN
            prefer_data_q <= prefer_data_d;
`endif
        end
    end

    // Outputs are pure decodes of the flops, except the read data, which is
    // a combinational pass-through of m_rdata on the ack cycle.
    always_comb begin
        ack_now = (state_q == WAIT) && (cnt_q == CNT_LAST);

        m_en    = (state_q == ISSUE);
        m_addr  = m_en ? addr_q  : 32'd0;
        m_wdata = m_en ? wdata_q : 32'd0;
        m_be    = m_en ? be_q    : 4'd0;

        i_ack   = ack_now && !grant_data_q;
        d_ack   = ack_now &&  grant_data_q;
        i_rdata = i_ack ? m_rdata : 32'd0;
        d_rdata = d_ack ? m_rdata : 32'd0;

        gnt_d   = (state_q != IDLE) && grant_data_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. Two instances share all inputs:
//   dut1 (LATENCY=1) and dut3 (LATENCY=3); 'sel' picks whose outputs are
//   compared. Directed vectors are kept in a table of {stimulus, expected}
//   records; multi-cycle corners (mid-transaction reset, LATENCY=3) are
//   written inline; random traffic is checked against a transaction-level
//   reference model that schedules strobe/ack cycles with plain arithmetic.
//   Honors MEM_ARBITER_RR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic [31:0] m_rdata;
    } stim_t;

    typedef struct packed {
        logic        m_en;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic [3:0]  m_be;
        logic        i_ack;
        logic [31:0] i_rdata;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        chk_drd;
        logic        gnt_d;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] m_rdata;
    logic        sel;

    logic [31:0] i_rdata1, d_rdata1, m_addr1, m_wdata1;
    logic        i_ack1, d_ack1, m_en1, gnt_d1;
    logic [3:0]  m_be1;
    logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3;
    logic        i_ack3, d_ack3, m_en3, gnt_d3;
    logic [3:0]  m_be3;

    exp_t act1, act3, act;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .m_en(m_en1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_be(m_be1),
        .m_rdata(m_rdata), .gnt_d(gnt_d1)
    );

    mem_arbiter #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata3), .d_ack(d_ack3),
        .m_en(m_en3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_be(m_be3),
        .m_rdata(m_rdata), .gnt_d(gnt_d3)
    );

    assign act1 = {m_en1, m_addr1, m_wdata1, m_be1, i_ack1, i_rdata1,
                   d_ack1, d_rdata1, 1'b0, gnt_d1};
    assign act3 = {m_en3, m_addr3, m_wdata3, m_be3, i_ack3, i_rdata3,
                   d_ack3, d_rdata3, 1'b0, gnt_d3};

    always_comb begin
        act = sel ? act3 : act1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- record builders ----------------
    function automatic stim_t st(input logic r, input logic ireq,
                                 input logic [31:0] ia, input logic dreq,
                                 input logic [31:0] da, input logic [31:0] dw,
                                 input logic [3:0] be, input logic [31:0] mrd);
        stim_t s;
        s.rst = r; s.i_req = ireq; s.i_addr = ia; s.d_req = dreq;
        s.d_addr = da; s.d_wdata = dw; s.d_be = be; s.m_rdata = mrd;
        return s;
    endfunction

    function automatic exp_t expIdle();
        exp_t e;
        e = '0;
        e.chk_drd = 1'b1;
        return e;
    endfunction

    function automatic exp_t expIssue(input logic [31:0] a, input logic [31:0] w,
                                      input logic [3:0] be, input logic g);
        exp_t e;
        e = expIdle();
        e.m_en = 1'b1; e.m_addr = a; e.m_wdata = w; e.m_be = be; e.gnt_d = g;
        return e;
    endfunction

    function automatic exp_t expIAck(input logic [31:0] rd);
        exp_t e;
        e = expIdle();
        e.i_ack = 1'b1; e.i_rdata = rd;
        return e;
    endfunction

    function automatic exp_t expDAck(input logic [31:0] rd, input logic chk);
        exp_t e;
        e = expIdle();
        e.d_ack = 1'b1; e.d_rdata = rd; e.chk_drd = chk; e.gnt_d = 1'b1;
        return e;
    endfunction

    function automatic vec_t mk(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        return v;
    endfunction

    // ---------------- drive / compare ----------------
    task automatic applyStimulus(input stim_t s);
        rst = s.rst; i_req = s.i_req; i_addr = s.i_addr;
        d_req = s.d_req; d_addr = s.d_addr; d_wdata = s.d_wdata;
        d_be = s.d_be; m_rdata = s.m_rdata;
    endtask

    task automatic checkField(input string tag, input string f,
                              input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, f, a, x);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        exp_t a;
        a = act;
        checkField(tag, "m_en",    32'(a.m_en),  32'(e.m_en));
        checkField(tag, "m_addr",  a.m_addr,     e.m_addr);
        checkField(tag, "m_wdata", a.m_wdata,    e.m_wdata);
        checkField(tag, "m_be",    32'(a.m_be),  32'(e.m_be));
        checkField(tag, "i_ack",   32'(a.i_ack), 32'(e.i_ack));
        checkField(tag, "i_rdata", a.i_rdata,    e.i_rdata);
        checkField(tag, "d_ack",   32'(a.d_ack), 32'(e.d_ack));
        if (e.chk_drd) checkField(tag, "d_rdata", a.d_rdata, e.d_rdata);
        checkField(tag, "gnt_d",   32'(a.gnt_d), 32'(e.gnt_d));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v.s);
        @(negedge clk);
        checkOutput(tag, v.e);
        nextCycle();
    endtask

    task automatic resetBoth();
        applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("in_reset", expIdle());
        nextCycle();
        rst = 1'b0;
    endtask

    // ---------------- transaction-level reference model ----------------
    int          mcyc, missue, mack, mlat;
    bit          mbusy, mport_d, mpref_d;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mbe;

    function automatic exp_t modelExpect(input logic [31:0] mrd);
        exp_t e;
        e = expIdle();
        if (mbusy) begin
            e.gnt_d = mport_d;
            if (mcyc == missue) begin
                e.m_en = 1'b1; e.m_addr = maddr; e.m_wdata = mwdata; e.m_be = mbe;
            end
            if (mcyc == mack) begin
                if (mport_d) begin
                    e.d_ack = 1'b1; e.d_rdata = mrd; e.chk_drd = (mbe == 4'd0);
                end else begin
                    e.i_ack = 1'b1; e.i_rdata = mrd;
                end
            end
        end
        return e;
    endfunction

    task automatic modelAdvance();
        bit pick_d;
        if (!mbusy) begin
            if (i_req || d_req) begin
`ifdef MEM_ARBITER_RR_EN
                pick_d = (i_req && d_req) ? mpref_d : d_req;
                mpref_d = !pick_d;
`else
                pick_d = d_req;
`endif
                mport_d = pick_d;
                maddr   = pick_d ? d_addr  : i_addr;
                mwdata  = pick_d ? d_wdata : 32'd0;
                mbe     = pick_d ? d_be    : 4'd0;
                mbusy   = 1'b1;
                missue  = mcyc + 1;
                mack    = mcyc + 1 + mlat;
            end
        end else if (mcyc == mack) begin
            mbusy = 1'b0;
        end
        mcyc++;
    endtask

    task automatic newFetch();
        i_req = 1'b1; i_addr = $urandom;
    endtask

    task automatic newData();
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        d_be = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
    endtask

    task automatic runRandom(input bit which, input int lat, input int n);
        exp_t e;
        bit   iacked, dacked;
        sel = which;
        resetBoth();
        mcyc = 0; mbusy = 0; mpref_d = 0; mlat = lat;
        iacked = 0; dacked = 0;
        for (int k = 0; k < n; k++) begin
            if (i_req && iacked) begin
                if ($urandom_range(1) == 0) newFetch(); else i_req = 1'b0;
            end else if (!i_req && $urandom_range(2) == 0) begin
                newFetch();
            end
            if (d_req && dacked) begin
                if ($urandom_range(1) == 0) newData(); else d_req = 1'b0;
            end else if (!d_req && $urandom_range(2) == 0) begin
                newData();
            end
            m_rdata = $urandom;
            e = modelExpect(m_rdata);
            @(negedge clk);
            checkOutput($sformatf("rand_l%0d_c%0d", lat, k), e);
            iacked = e.i_ack;
            dacked = e.d_ack;
            modelAdvance();
            nextCycle();
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[$];

    initial begin
        sel = 1'b0;
        applyStimulus(st(1, 0, 0, 0, 0, 0, 0, 0));

        // Directed table for the LATENCY=1 instance.
        // Single fetch, expected strobe at +1 and ack at +2.
        vecs.push_back(mk(st(0, 1, 'h10, 0, 0, 0, 0, 0),          expIdle()));
        vecs.push_back(mk(st(0, 1, 'h10, 0, 0, 0, 0, 0),          expIssue('h10, 0, 0, 0)));
        vecs.push_back(mk(st(0, 1, 'h10, 0, 0, 0, 0, 'hDEADBEEF), expIAck('hDEADBEEF)));
        vecs.push_back(mk(st(0, 0, 0, 0, 0, 0, 0, 'h1),           expIdle()));
        // Partial store; d_rdata is don't-care on the ack.
        vecs.push_back(mk(st(0, 0, 0, 1, 'h100, 'h12345678, 4'b0011, 0),          expIdle()));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h100, 'h12345678, 4'b0011, 0),          expIssue('h100, 'h12345678, 4'b0011, 1)));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h100, 'h12345678, 4'b0011, 'hCAFEF00D), expDAck(0, 0)));
        vecs.push_back(mk(st(0, 0, 0, 0, 0, 0, 0, 'h2),                           expIdle()));
        // Both ports request together.
`ifdef MEM_ARBITER_RR_EN
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 0),          expIdle()));
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 0),          expIssue('h20, 0, 0, 0)));
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 'h33333333), expIAck('h33333333)));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h200, 'h55, 0, 0),             expIdle()));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h200, 'h55, 0, 0),             expIssue('h200, 'h55, 0, 1)));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h200, 'h55, 0, 'h44444444),    expDAck('h44444444, 1)));
`else
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 0),          expIdle()));
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 0),          expIssue('h200, 'h55, 0, 1)));
        vecs.push_back(mk(st(0, 1, 'h20, 1, 'h200, 'h55, 0, 'h11111111), expDAck('h11111111, 1)));
        vecs.push_back(mk(st(0, 1, 'h20, 0, 0, 0, 0, 0),                 expIdle()));
        vecs.push_back(mk(st(0, 1, 'h20, 0, 0, 0, 0, 0),                 expIssue('h20, 0, 0, 0)));
        vecs.push_back(mk(st(0, 1, 'h20, 0, 0, 0, 0, 'h22222222),        expIAck('h22222222)));
`endif
        vecs.push_back(mk(st(0, 0, 0, 0, 0, 0, 0, 'h3), expIdle()));
        // Inputs that change while a fetch is in flight must not affect it.
        vecs.push_back(mk(st(0, 1, 'h60, 0, 0, 0, 0, 0),                    expIdle()));
        vecs.push_back(mk(st(0, 1, 'h64, 1, 'h400, 'h9, 4'hF, 0),           expIssue('h60, 0, 0, 0)));
        vecs.push_back(mk(st(0, 1, 'h64, 1, 'h400, 'h9, 4'hF, 'hABCD0123), expIAck('hABCD0123)));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h400, 'h9, 4'hF, 0),              expIdle()));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h400, 'h9, 4'hF, 0),              expIssue('h400, 'h9, 4'hF, 1)));
        vecs.push_back(mk(st(0, 0, 0, 1, 'h400, 'h9, 4'hF, 'h5),            expDAck(0, 0)));
        vecs.push_back(mk(st(0, 0, 0, 0, 0, 0, 0, 'h6),                     expIdle()));

        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_l1", expIdle());
        sel = 1'b1;
        checkOutput("reset_l3", expIdle());
        sel = 1'b0;
        nextCycle();

        for (int k = 0; k < vecs.size(); k++) begin
            runVec(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset asserted during the strobe cycle of a load: no ack, quiet outputs.
        runVec(mk(st(0, 0, 0, 1, 'h300, 0, 0, 0),     expIdle()), "rstmid_c0");
        runVec(mk(st(1, 0, 0, 1, 'h300, 0, 0, 'h77),  expIdle()), "rstmid_c1");
        runVec(mk(st(1, 0, 0, 0, 0, 0, 0, 'h77),      expIdle()), "rstmid_c2");
        runVec(mk(st(0, 0, 0, 0, 0, 0, 0, 'h77),      expIdle()), "rstmid_c3");
        runVec(mk(st(0, 1, 'h44, 0, 0, 0, 0, 0),      expIdle()), "after_rst_c0");
        runVec(mk(st(0, 1, 'h44, 0, 0, 0, 0, 0),      expIssue('h44, 0, 0, 0)), "after_rst_c1");
        runVec(mk(st(0, 1, 'h44, 0, 0, 0, 0, 'h99),   expIAck('h99)), "after_rst_c2");
        runVec(mk(st(0, 0, 0, 0, 0, 0, 0, 'h7),       expIdle()), "after_rst_c3");

        // LATENCY=3 fetch: strobe at +1, silence for two cycles, ack at +4.
        sel = 1'b1;
        resetBoth();
        runVec(mk(st(0, 1, 'h40, 0, 0, 0, 0, 0),          expIdle()), "lat3_c0");
        runVec(mk(st(0, 1, 'h40, 0, 0, 0, 0, 'h1),        expIssue('h40, 0, 0, 0)), "lat3_c1");
        runVec(mk(st(0, 1, 'h40, 0, 0, 0, 0, 'h2),        expIdle()), "lat3_c2");
        runVec(mk(st(0, 1, 'h40, 0, 0, 0, 0, 'h3),        expIdle()), "lat3_c3");
        runVec(mk(st(0, 1, 'h40, 0, 0, 0, 0, 'hFEEDFACE), expIAck('hFEEDFACE)), "lat3_c4");
        runVec(mk(st(0, 0, 0, 0, 0, 0, 0, 'h4),           expIdle()), "lat3_c5");

        runRandom(1'b0, 1, 400);
        runRandom(1'b1, 3, 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
